// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID pipeline register under branch/jump redirect, stall and flush control.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_HOLD   = 2'd3
    } pc_sel_e;

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_next_s;
    logic [31:0] instr_next_s;
    logic        valid_next_s;
    logic [31:0] count_next_s;
    logic [31:0] if_id_pc_plus4_r;
    logic [31:0] if_id_instr_r;
    logic        if_id_valid_r;
    logic [31:0] fetch_count_r;
    pc_sel_e     pc_sel_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Redirect priority: the branch belongs to the older instruction, so it beats stall and jump.
    always_comb begin
        pc_sel_s = SEL_SEQ;
        if (branch_taken) begin
            pc_sel_s = SEL_BRANCH;
        end else if (jump && !stall) begin
            pc_sel_s = SEL_JUMP;
        end else if (stall) begin
            pc_sel_s = SEL_HOLD;
        end else begin
            pc_sel_s = SEL_SEQ;
        end
    end

    // Next-state values for PC, IF/ID and the fetch counter.
    always_comb begin
        pc_next_s       = pc_r;
        pc_plus4_next_s = if_id_pc_plus4_r;
        instr_next_s    = if_id_instr_r;
        valid_next_s    = if_id_valid_r;
        count_next_s    = fetch_count_r;
        case (pc_sel_s)
            SEL_BRANCH: begin
                pc_next_s       = {branch_target[31:2], 2'b00};
                pc_plus4_next_s = 32'd0;
                instr_next_s    = NOP_WORD;
                valid_next_s    = 1'b0;
            end
            SEL_JUMP: begin
                pc_next_s       = {jump_target[31:2], 2'b00};
                pc_plus4_next_s = 32'd0;
                instr_next_s    = NOP_WORD;
                valid_next_s    = 1'b0;
            end
            SEL_HOLD: begin
                pc_next_s       = pc_r;
                pc_plus4_next_s = if_id_pc_plus4_r;
                instr_next_s    = if_id_instr_r;
                valid_next_s    = if_id_valid_r;
            end
            SEL_SEQ: begin
                pc_next_s       = pc_plus4_s;
                pc_plus4_next_s = pc_plus4_s;
                instr_next_s    = imem_instr;
                valid_next_s    = 1'b1;
                count_next_s    = fetch_count_r + 32'd1;
            end
            default: begin
                pc_next_s       = pc_r;
                pc_plus4_next_s = if_id_pc_plus4_r;
                instr_next_s    = if_id_instr_r;
                valid_next_s    = if_id_valid_r;
            end
        endcase
    end

    // PC, IF/ID and fetch-counter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r             <= RESET_PC;
            if_id_pc_plus4_r <= 32'd0;
            if_id_instr_r    <= NOP_WORD;
            if_id_valid_r    <= 1'b0;
            fetch_count_r    <= 32'd0;
        end else begin
            pc_r             <= pc_next_s;
            if_id_pc_plus4_r <= pc_plus4_next_s;
            if_id_instr_r    <= instr_next_s;
            if_id_valid_r    <= valid_next_s;
            fetch_count_r    <= count_next_s;
        end
    end

    assign imem_addr      = pc_r;
    assign if_id_pc_plus4 = if_id_pc_plus4_r;
    assign if_id_instr    = if_id_instr_r;
    assign if_id_valid    = if_id_valid_r;
    assign fetch_count    = fetch_count_r;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected post-edge state from a
// behavioural fetch model; an independent monitor pops and compares after each edge.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    exp_t        sb_q[$];
    int          checks;
    int          failures;
    logic        end_req;

    // Model state: architectural view of the fetch stage.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_count;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            32'h0040_0000: w = 32'h2004_0020;
            32'h0040_0004: w = 32'h2005_0000;
            default:       w = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        endcase
        return w;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_pc    = RST_PC;
        m_instr = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
        m_count = 32'd0;
    endtask

    // Drive one cycle of inputs at a falling edge, predict, push, advance to next falling edge.
    task automatic step(input logic st, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        exp_t e;
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        if (br) begin
            m_pc = bt & 32'hFFFF_FFFC;
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (jp && !st) begin
            m_pc = jt & 32'hFFFF_FFFC;
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem_word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.count = m_count;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reset values while reset is low, otherwise pop one expectation per edge.
    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (!reset) begin
                chk("rst_imem_addr", imem_addr, RST_PC);
                chk("rst_instr", if_id_instr, 32'd0);
                chk("rst_pc4", if_id_pc_plus4, 32'd0);
                chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
                chk("rst_count", fetch_count, 32'd0);
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("imem_addr", imem_addr, e.pc);
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
                chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                chk("fetch_count", fetch_count, e.count);
            end
            if (end_req) begin
                checks++;
                if (sb_q.size() != 0) begin
                    failures++;
                    $display("FAIL drain actual=%0d expected=0", sb_q.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        end_req       = 1'b0;
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump          = 1'b0;
        jump_target   = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Free fetch from reset, then a three-cycle stall at 0x00400008.
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Jump redirect, then a jump that is masked by stall.
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0028);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'h0040_0100);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Branch wins over a simultaneous stall and jump; unaligned target.
        step(1'b1, 1'b1, 32'h0040_001F, 1'b1, 32'h0040_0200);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Wrap past 0xFFFFFFFC, with back-to-back branches first.
        step(1'b0, 1'b1, 32'h0040_0300, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Asynchronous reset in the middle of a branch redirect cycle.
        branch_taken  = 1'b1;
        branch_target = 32'h0123_4567;
        #2 reset = 1'b0;
        @(negedge clk);
        branch_taken = 1'b0;
        reset        = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Randomized hazard mix.
        for (int i = 0; i < 400; i++) begin
            logic        st, br, jp;
            logic [31:0] bt, jt;
            st = ($urandom_range(0, 99) < 25);
            br = ($urandom_range(0, 99) < 8);
            jp = ($urandom_range(0, 99) < 12);
            bt = ($urandom_range(0, 9) == 0) ? $urandom() : (32'h0040_0000 | ($urandom() & 32'h0000_0FFF));
            jt = ($urandom_range(0, 9) == 0) ? $urandom() : (32'h0040_0000 | ($urandom() & 32'h0000_0FFF));
            step(st, br, bt, jp, jt);
        end

        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        end_req = 1'b1;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction-memory address.
- Captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Applies next-PC selection (sequential, EX-stage branch redirect, ID-stage jump/jr redirect) plus stall and flush control; keeps a fetch counter for the debug/LED path.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (text-segment base).
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals PC register, combinational.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  load-use hazard from ID; hold PC and IF/ID.
- branch_taken  input  1  EX-stage branch resolved taken.
- branch_target  input  32  EX-stage branch target byte address.
- jump  input  1  ID-stage j/jal/jr redirect (ID selects the target).
- jump_target  input  32  ID-stage jump target byte address.
- if_id_pc_plus4  output  32  PC+4 of the latched instruction.
- if_id_instr  output  32  latched instruction word.
- if_id_valid  output  1  latched instruction is on the correct path.
- fetch_count  output  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (reset=0, async, any time including mid-redirect):
  - pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0.
  - First fetch is from RESET_PC on the first rising edge after reset deasserts.
- imem_addr = pc, with zero added latency. Instruction memory is combinational, so imem_instr is sampled in the same cycle.
- Per-edge priority, highest first:
  1. branch_taken=1:
     - pc <= {branch_target[31:2],2'b00}.
     - IF/ID <= {0, NOP_WORD, valid=0}.
     - Overrides stall and jump (branch belongs to the older instruction).
  2. jump=1 and stall=0:
     - pc <= {jump_target[31:2],2'b00}.
     - IF/ID flushed as above (no delay slot).
  3. stall=1:
     - pc and all IF/ID fields hold.
     - jump is ignored while stalled; ID re-asserts it after the stall clears.
  4. otherwise:
     - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
     - IF/ID <= {pc+4, imem_instr, valid=1}.
- Redirect targets always have bits[1:0] forced to 0; no misalignment exception.
- fetch_count:
  - Increments by 1 on exactly those edges where case 4 applies.
  - Wraps modulo 2^32.
  - Never changes on stall or flush.
- One-cycle redirect penalty for jump; two-cycle penalty for branch. The upstream ID/EX flush is owned by the hazard unit, not this block.
- No internal FSM beyond the valid bit; a back-to-back redirect (branch_taken two cycles in a row) is legal and each one takes effect.
- Outputs are registered except imem_addr, so no combinational path exists from stall/branch inputs to the if_id_* outputs.

Test Plan:
1. Reset release, memory word0=32'h20040020, word1=32'h20050000, no hazards:
   - imem_addr sequence 0x00400000, 0x00400004, 0x00400008.
   - After edge 1: if_id_instr=32'h20040020, if_id_pc_plus4=0x00400004, valid=1, fetch_count=1.
2. Stall held 3 cycles at pc=0x00400008:
   - pc and IF/ID unchanged for 3 edges; fetch_count unchanged.
   - Fetch resumes at 0x00400008 on the first edge with stall=0.
3. jump=1, jump_target=0x00400028, stall=0:
   - Next pc=0x00400028; IF/ID valid=0, instr=0; fetch_count unchanged that cycle.
   - Repeat with stall=1: jump ignored, all state holds.
4. branch_taken=1, branch_target=0x0040001F, with stall=1 and jump=1 in the same cycle:
   - pc=0x0040001C (low bits cleared, branch wins); IF/ID flushed.
5. Wrap case: force pc to 0xFFFFFFFC via branch_target, then run free:
   - Next imem_addr=0x00000000; if_id_pc_plus4=0x00000000 for the word fetched at 0xFFFFFFFC.
6. Assert reset low mid-cycle during a branch redirect:
   - All outputs return to reset values immediately (async, before the next edge).
   - imem_addr=0x00400000; fetch_count=0.
